// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 32;
  localparam int IFU_DATA_W = 32;
  localparam int IFU_DEPTH  = 2;

  // Low address bits that must be zero for a word-aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] instr;
    logic [IFU_ADDR_W-1:0] pc;
    logic                  fault;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// PC, instruction-memory and decode handshakes of the fetch unit, bundled.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_addr;
  logic              pc_valid;
  logic              pc_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_fault;
  logic              if_ready;

  modport master (
    input  pc_addr, pc_valid, mem_ack, mem_rdata, flush, if_ready,
    output pc_ready, mem_req, mem_addr, if_valid, if_instr, if_pc, if_fault
  );

  modport slave (
    output pc_addr, pc_valid, mem_ack, mem_rdata, flush, if_ready,
    input  pc_ready, mem_req, mem_addr, if_valid, if_instr, if_pc, if_fault
  );
endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; flush wins over a simultaneous push or pop.
module fetch_fifo #(
  parameter int  WIDTH = 65,
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] slot_w [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i & ~flush_i & ~full_o;
  assign do_pop  = pop_i  & ~flush_i & ~empty_o;
  assign head_o  = slot_w[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slots are reset so the head reads as zero out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        slot_q <= '0;
      else if (do_push && (wr_ptr_q == PTR_W'(gi)))
        slot_q <= push_data_i;
    end
    assign slot_w[gi] = slot_q;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: takes PCs, reads instruction memory one word at a time, queues results for decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W,
  parameter int DEPTH  = IFU_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_fetch_unit_if.master     bus
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              pc_fire, misaligned;

  // An outstanding request already holds its FIFO slot, so PCs are only taken from IDLE.
  assign bus.pc_ready = ~reset & (state_q == ST_IDLE) & ~bus.flush
                      & (fifo_count < CNT_W'(DEPTH));
  assign pc_fire      = bus.pc_valid & bus.pc_ready;
  assign misaligned   = is_misaligned(bus.pc_addr[1:0]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    push      = 1'b0;
    push_data = {{DATA_W{1'b0}}, bus.pc_addr, 1'b1};
    unique case (state_q)
      ST_IDLE: begin
        if (pc_fire) begin
          if (misaligned) begin
            push = 1'b1;
          end else begin
            state_d = ST_WAIT;
            addr_d  = bus.pc_addr;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          push      = ~bus.flush;
          push_data = {bus.mem_rdata, addr_q, 1'b0};
        end else if (bus.flush) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (bus.mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // The request stays up through DROP: memory must still see its ack.
  assign bus.mem_req  = (state_q != ST_IDLE);
  assign bus.mem_addr = addr_q & ~{{(ADDR_W-2){1'b0}}, ALIGN_MASK};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.if_ready),
    .flush_i     (bus.flush),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.if_valid = ~fifo_empty;
  assign {bus.if_instr, bus.if_pc, bus.if_fault} = fifo_head;

  a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  inst_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued instructions plus one outstanding memory read.
  fetch_entry_t q[$];
  logic [31:0]  pcq[$];
  bit           busy, stale, exp_ready;
  logic [31:0]  req_addr;
  int           lat_cnt, lat;
  bit           lat_rand, auto_pc, auto_mem;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    bit          s_pcv, s_flush, s_ack, s_rdy, acc;
    logic [31:0] s_addr, s_rdata;
    fetch_entry_t e;
    if (auto_pc) begin
      bus.pc_valid = (pcq.size() != 0);
      if (pcq.size() != 0) bus.pc_addr = pcq[0];
    end
    if (auto_mem) begin
      bus.mem_ack   = busy && (lat_cnt == 0);
      bus.mem_rdata = bus.mem_ack ? word_at(req_addr) : $urandom();
    end
    #1;
    exp_ready = !busy && !bus.flush && (q.size() < DEPTH);
    chk("pc_ready", 64'(bus.pc_ready), 64'(exp_ready));
    chk("mem_req",  64'(bus.mem_req),  64'(busy));
    if (busy) chk("mem_addr", 64'(bus.mem_addr), 64'(req_addr));
    chk("if_valid", 64'(bus.if_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_instr", 64'(bus.if_instr), 64'(q[0].instr));
      chk("if_pc",    64'(bus.if_pc),    64'(q[0].pc));
      chk("if_fault", 64'(bus.if_fault), 64'(q[0].fault));
    end
    s_pcv = bus.pc_valid;  s_addr  = bus.pc_addr;
    s_ack = bus.mem_ack;   s_rdata = bus.mem_rdata;
    s_flush = bus.flush;   s_rdy   = bus.if_ready;
    @(posedge clk); #1;
    acc = s_pcv && exp_ready;
    if (s_flush) q.delete();
    else if (s_rdy && q.size() != 0) begin
      $display("decode pc=%08h instr=%08h fault=%0d", q[0].pc, q[0].instr, q[0].fault);
      void'(q.pop_front());
    end
    if (busy) begin
      if (s_ack) begin
        if (!stale && !s_flush) begin
          e.instr = s_rdata; e.pc = req_addr; e.fault = 1'b0;
          q.push_back(e);
        end
        busy = 0; stale = 0;
      end else begin
        if (s_flush) stale = 1;
        if (lat_cnt > 0) lat_cnt--;
      end
    end
    if (acc) begin
      if (auto_pc) void'(pcq.pop_front());
      if (s_addr[1:0] != 2'b00) begin
        e.instr = '0; e.pc = s_addr; e.fault = 1'b1;
        q.push_back(e);
      end else begin
        busy = 1; req_addr = s_addr;
        lat_cnt = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pc_valid = 0; bus.pc_addr = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
    bus.flush = 0; bus.if_ready = 0;
    #1;
    chk("rst_pc_ready", 64'(bus.pc_ready), 64'd0);
    chk("rst_mem_req",  64'(bus.mem_req),  64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
    chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
    chk("rst_if_pc",    64'(bus.if_pc),    64'd0);
    chk("rst_if_fault", 64'(bus.if_fault), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); pcq.delete();
    busy = 0; stale = 0; lat_cnt = 0; req_addr = '0;
  endtask

  initial begin
    logic [31:0] r;
    auto_pc = 0; auto_mem = 0; lat_rand = 0; lat = 0;
    #2;
    do_reset();

    // Aligned fetch, ack three cycles into the request.
    bus.pc_addr = 32'h0; bus.pc_valid = 1; step(); bus.pc_valid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin bus.mem_ack = 1; bus.mem_rdata = 32'h0010_0093; end
      #1;
      chk("t1_mem_req_held", 64'(bus.mem_req),  64'd1);
      chk("t1_mem_addr",     64'(bus.mem_addr), 64'd0);
      step();
    end
    bus.mem_ack = 0; #1;
    chk("t1_mem_req_drop", 64'(bus.mem_req),  64'd0);
    chk("t1_if_valid",     64'(bus.if_valid), 64'd1);
    chk("t1_if_instr",     64'(bus.if_instr), 64'h0010_0093);
    chk("t1_if_pc",        64'(bus.if_pc),    64'd0);
    chk("t1_if_fault",     64'(bus.if_fault), 64'd0);
    bus.if_ready = 1; step(); bus.if_ready = 0;

    // Back-to-back PCs with decode stalled: reservation stops at two entries.
    auto_pc = 1; auto_mem = 1; lat = 0;
    pcq = '{32'h0, 32'h4, 32'h8};
    repeat (6) step();
    #1;
    chk("t2_pc_ready_full", 64'(bus.pc_ready),   64'd0);
    chk("t2_count_full",    64'(dut.fifo_count), 64'd2);
    chk("t2_head_pc",       64'(bus.if_pc),      64'd0);
    bus.if_ready = 1; step(); bus.if_ready = 0;
    repeat (3) step();
    #1;
    chk("t2_count_refill",  64'(dut.fifo_count), 64'd2);
    chk("t2_head_pc_next",  64'(bus.if_pc),      64'h4);
    bus.if_ready = 1; step(); #1;
    chk("t2_tail_pc",       64'(bus.if_pc),      64'h8);
    step(); bus.if_ready = 0;
    auto_pc = 0; auto_mem = 0; bus.pc_valid = 0; bus.mem_ack = 0;

    // Misaligned fetch faults without touching memory.
    bus.pc_addr = 32'h6; bus.pc_valid = 1; step(); bus.pc_valid = 0; #1;
    chk("t3_mem_req",  64'(bus.mem_req),  64'd0);
    chk("t3_if_valid", 64'(bus.if_valid), 64'd1);
    chk("t3_if_fault", 64'(bus.if_fault), 64'd1);
    chk("t3_if_instr", 64'(bus.if_instr), 64'd0);
    chk("t3_if_pc",    64'(bus.if_pc),    64'h6);
    bus.if_ready = 1; step(); bus.if_ready = 0;

    // Flush in WAIT, ack two cycles later is dropped.
    bus.pc_addr = 32'h10; bus.pc_valid = 1; step(); bus.pc_valid = 0;
    step();
    bus.flush = 1; step(); bus.flush = 0; #1;
    chk("t4_state_drop",  64'(dut.state_q),  64'(ST_DROP));
    chk("t4_pc_ready",    64'(bus.pc_ready), 64'd0);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 32'hDEAD_BEEF; step(); bus.mem_ack = 0; #1;
    chk("t4_pc_ready_back", 64'(bus.pc_ready), 64'd1);
    chk("t4_if_valid",      64'(bus.if_valid), 64'd0);
    chk("t4_no_stale_data", 64'(bus.if_instr !== 32'hDEAD_BEEF), 64'd1);
    repeat (2) step();

    // Flush coinciding with ack while the FIFO holds an entry.
    bus.pc_addr = 32'h3;  bus.pc_valid = 1; step();
    bus.pc_addr = 32'h20; step(); bus.pc_valid = 0;
    step();
    bus.flush = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h1234_5678; step();
    bus.flush = 0; bus.mem_ack = 0; #1;
    chk("t5_if_valid", 64'(bus.if_valid),   64'd0);
    chk("t5_count",    64'(dut.fifo_count), 64'd0);
    chk("t5_state",    64'(dut.state_q),    64'(ST_IDLE));
    chk("t5_mem_req",  64'(bus.mem_req),    64'd0);
    chk("t5_pc_ready", 64'(bus.pc_ready),   64'd1);

    // Reset in WAIT, then a stray ack, then a normal fetch.
    bus.pc_addr = 32'h40; bus.pc_valid = 1; step(); bus.pc_valid = 0;
    step();
    #3;
    do_reset();
    chk("t6_state", 64'(dut.state_q), 64'(ST_IDLE));
    bus.mem_ack = 1; bus.mem_rdata = 32'h0BAD_0BAD; step(); bus.mem_ack = 0; #1;
    chk("t6_stray_mem_req",  64'(bus.mem_req),  64'd0);
    chk("t6_stray_if_valid", 64'(bus.if_valid), 64'd0);
    auto_pc = 1; auto_mem = 1; lat = 1;
    pcq = '{32'h44};
    repeat (5) step(); #1;
    chk("t6_if_valid", 64'(bus.if_valid), 64'd1);
    chk("t6_if_pc",    64'(bus.if_pc),    64'h44);
    chk("t6_if_instr", 64'(bus.if_instr), 64'(word_at(32'h44)));
    bus.if_ready = 1; step(); bus.if_ready = 0;

    // Randomized traffic: latency, stalls, flushes, misaligned PCs.
    lat_rand = 1;
    for (int c = 0; c < 500; c++) begin
      if (pcq.size() == 0) begin
        for (int k = 0; k < 8; k++) begin
          r = $urandom();
          r[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          pcq.push_back(r);
        end
      end
      bus.if_ready = ($urandom_range(0, 3) != 0);
      bus.flush    = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.flush = 0; auto_pc = 0; bus.pc_valid = 0; bus.if_ready = 1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
